// File: rtl/booth_r4_decode_acc.sv
// Radix-4 Booth digit decoder and serial accumulator: one pre-decoded digit
// per cycle is turned into a partial product and summed into a 2*WIDTH product.
//
// state | meaning
// IDLE  | waiting for an operand/digit set, in_ready high
// RUN   | adding one partial product per cycle, digit 0 first
// DONE  | product presented on result until the output handshake
module booth_r4_decode_acc #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     op_1,
   input  logic [WIDTH/2:0]     val,
   input  logic [WIDTH/2:0]     sign,
   input  logic [WIDTH/2:0]     double,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   result,
   output logic                 busy
);

   localparam int NUM = WIDTH/2 + 1;
   localparam int D   = WIDTH/2;
   localparam int CW  = $clog2(NUM);
   localparam logic [CW-1:0] CNT_LAST = CW'(D - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [WIDTH-1:0]     op_q, op_d;
   logic [NUM-1:0]       val_q, val_d;
   logic [NUM-1:0]       sign_q, sign_d;
   logic [NUM-1:0]       dbl_q, dbl_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   res_q, res_d;
   logic [2*WIDTH-1:0]   pp;
   logic [2*WIDTH-1:0]   sum;

   // Partial product of the digit selected by cnt_q; the top digit is never addressed.
   always_comb begin
      pp = {{WIDTH{op_q[WIDTH-1]}}, op_q};
      if (dbl_q[cnt_q])
         pp = pp << 1;
      if (sign_q[cnt_q])
         pp = -pp;
      if (!val_q[cnt_q])
         pp = '0;
      pp  = pp << {cnt_q, 1'b0};
      sum = acc_q + pp;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      val_d     = val_q;
      sign_d    = sign_q;
      dbl_d     = dbl_q;
      acc_d     = acc_q;
      res_d     = res_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               op_d    = op_1;
               val_d   = val;
               sign_d  = sign;
               dbl_d   = double;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d = sum;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               res_d   = sum;
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         val_q   <= '0;
         sign_q  <= '0;
         dbl_q   <= '0;
         acc_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         val_q   <= val_d;
         sign_q  <= sign_d;
         dbl_q   <= dbl_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
      end
   end

   assign result = res_q;
   assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_booth_r4_decode_acc.sv
// Directed bench for booth_r4_decode_acc at WIDTH=8 with hand-computed products.
module tb_booth_r4_decode_acc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  op_1;
   logic [4:0]  val;
   logic [4:0]  sign;
   logic [4:0]  double;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic        busy;

   int vectors = 0;
   int errors  = 0;

   booth_r4_decode_acc #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_1      (op_1),
      .val       (val),
      .sign      (sign),
      .double    (double),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Drives one accepted set and waits (bounded) for out_valid; lat = -1 on timeout.
   task automatic run_op(input logic [7:0] o, input logic [4:0] v, input logic [4:0] s,
                         input logic [4:0] d, output int lat, output logic [15:0] res);
      op_1 = o; val = v; sign = s; double = d; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            lat = k;
            break;
         end
      end
      res = result;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      op_1 = 8'hA5; val = '1; sign = '1; double = '1;
      #12;
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 16'h0000) begin
         errors++;
         $display("FAIL reset: in_ready=%b out_valid=%b busy=%b result=%h, required 1 0 0 0000",
                  in_ready, out_valid, busy, result);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Accept happens on the first rising edge after reset release.
   task automatic test_basic();
      int lat; logic [15:0] res;
      vectors++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_ready: in_ready=%b required 1", in_ready);
      end
      run_op(8'h07, 5'b00011, 5'b00001, 5'b00000, lat, res);
      vectors++;
      if (lat !== 4) begin
         errors++;
         $display("FAIL basic_latency: got %0d required 4", lat);
      end
      vectors++;
      if (res !== 16'h0015) begin
         errors++;
         $display("FAIL basic_result: got %h required 0015", res);
      end
      vectors++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL basic_done_flags: busy=%b in_ready=%b required 1 0", busy, in_ready);
      end
      handshake();
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'h0015) begin
         errors++;
         $display("FAIL basic_after_hs: in_ready=%b out_valid=%b result=%h required 1 0 0015",
                  in_ready, out_valid, result);
      end
   endtask

   task automatic test_patterns();
      logic [7:0]  ops [4] = '{8'h80, 8'h55, 8'h01, 8'hFF};
      logic [4:0]  vs  [4] = '{5'b01000, 5'b10000, 5'b01111, 5'b01111};
      logic [4:0]  ss  [4] = '{5'b01000, 5'b11111, 5'b00000, 5'b00101};
      logic [4:0]  ds  [4] = '{5'b01000, 5'b11111, 5'b01111, 5'b00000};
      logic [15:0] exp [4] = '{16'h4000, 16'h0000, 16'h00AA, 16'hFFCD};
      int lat; logic [15:0] res;
      for (int i = 0; i < 4; i++) begin
         run_op(ops[i], vs[i], ss[i], ds[i], lat, res);
         vectors++;
         if (lat !== 4 || res !== exp[i]) begin
            errors++;
            $display("FAIL pattern%0d: latency=%0d result=%h required 4 %h", i, lat, res, exp[i]);
         end
         handshake();
      end
   endtask

   task automatic test_stall();
      int lat; logic [15:0] res;
      run_op(8'h07, 5'b00011, 5'b00001, 5'b00000, lat, res);
      vectors++;
      if (lat !== 4 || res !== 16'h0015) begin
         errors++;
         $display("FAIL stall_first: latency=%0d result=%h required 4 0015", lat, res);
      end
      in_valid = 1'b1; op_1 = 8'h80; val = 5'b01000; sign = 5'b01000; double = 5'b01000;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         vectors++;
         if (result !== 16'h0015 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold%0d: result=%h in_ready=%b out_valid=%b required 0015 0 1",
                     c, result, in_ready, out_valid);
         end
      end
      in_valid = 1'b0;
      handshake();
      vectors++;
      if (in_ready !== 1'b1 || result !== 16'h0015) begin
         errors++;
         $display("FAIL stall_release: in_ready=%b result=%h required 1 0015", in_ready, result);
      end
   endtask

   task automatic test_reset_mid_run();
      bit seen = 0;
      op_1 = 8'h07; val = 5'b00011; sign = 5'b00001; double = 5'b00000; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || result !== 16'h0000 || in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midrun_reset: out_valid=%b result=%h in_ready=%b busy=%b required 0 0000 1 0",
                  out_valid, result, in_ready, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1;
      end
      vectors++;
      if (seen !== 1'b0 || result !== 16'h0000) begin
         errors++;
         $display("FAIL midrun_no_output: out_valid_seen=%b result=%h required 0 0000", seen, result);
      end
   endtask

   task automatic test_back_to_back();
      int          cyc [2] = '{-1, -1};
      logic [15:0] got [2] = '{16'hxxxx, 16'hxxxx};
      int          n = 0;
      op_1 = 8'h07; val = 5'b00011; sign = 5'b00001; double = 5'b00000;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      op_1 = 8'h80; val = 5'b01000; sign = 5'b01000; double = 5'b01000;
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk); #1;
         if (k == 6) in_valid = 1'b0;
         if (out_valid && n < 2) begin
            cyc[n] = k;
            got[n] = result;
            n++;
         end
      end
      out_ready = 1'b0;
      vectors++;
      if (cyc[0] !== 4 || got[0] !== 16'h0015) begin
         errors++;
         $display("FAIL b2b_first: cycle=%0d result=%h required 4 0015", cyc[0], got[0]);
      end
      vectors++;
      if (cyc[1] !== 10 || got[1] !== 16'h4000) begin
         errors++;
         $display("FAIL b2b_second: cycle=%0d result=%h required 10 4000", cyc[1], got[1]);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_patterns();
      test_stall();
      test_reset_mid_run();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/booth_r4_decode_acc.md
BOOTH_R4_DECODE_ACC -- requirements
Module: booth_r4_decode_acc

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be even and at least 4.
REQ-002 Derived constant NUM = WIDTH/2+1, the width of each digit vector; digit count used D = WIDTH/2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand/digit set is presented.
REQ-006 in_ready  output  1  block can accept a new set.
REQ-007 op_1  input  WIDTH  multiplicand, two's complement.
REQ-008 val  input  NUM  per-digit nonzero flag (bit i is digit i).
REQ-009 sign  input  NUM  per-digit negate flag, 1 = negative.
REQ-010 double  input  NUM  per-digit magnitude select, 1 = x2, 0 = x1.
REQ-011 out_valid  output  1  result is available.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 result  output  2*WIDTH  signed product, two's complement.
REQ-014 busy  output  1  high while in RUN or DONE.

Function
REQ-015 Digit decode SHALL be: val[i]=0 -> 0 (sign and double ignored); val[i]=1 -> magnitude (double[i] ? 2 : 1) times op_1, negated when sign[i]=1.
REQ-016 Partial product i SHALL be op_1 sign-extended to 2*WIDTH, shifted left by 1 when doubled, two's-complement negated when signed, then shifted left by 2*i; all arithmetic is modulo 2^(2*WIDTH).
REQ-017 Digit index D (top bit of val/sign/double) SHALL be ignored.
REQ-018 FSM states: IDLE, RUN, DONE.
REQ-019 IDLE: in_ready=1; on in_valid&&in_ready, capture op_1, val, sign and double; clear accumulator and digit counter; go to RUN.
REQ-020 RUN: each cycle add partial product of digit[cnt] to accumulator and increment cnt; after digit D-1 is added, go to DONE.
REQ-021 Latency: out_valid SHALL rise exactly D cycles after the accept edge (WIDTH=8: 4 cycles).
REQ-022 DONE: out_valid=1 and result holds the final accumulator; result stays stable until out_valid&&out_ready, then go to IDLE.
REQ-023 in_ready SHALL be 0 in RUN and DONE; in_valid there SHALL be ignored, and captured operands SHALL not change.
REQ-024 After the output handshake, in_ready SHALL be 1 in the following cycle; one result per D+2 cycles minimum throughput.
REQ-025 result SHALL be held at its last value in IDLE and RUN; out_valid SHALL be 0 outside DONE.
REQ-026 Input changes while not accepting SHALL have no effect on result.
REQ-027 The block SHALL not check digit legality; any combination decodes per REQ-015.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, in_ready=1, out_valid=0, busy=0, result=0, accumulator=0, cnt=0, captured registers=0.
REQ-029 Reset asserted mid-RUN or mid-DONE SHALL discard the operation; no out_valid pulse follows deassertion.
REQ-030 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification (WIDTH=8)
REQ-031 op_1=8'h07, digit0=-1 (val=1,sign=1,double=0), digit1=+1, digits 2..3 val=0 -> after 4 cycles out_valid=1, result=16'h0015.
REQ-032 op_1=8'h80, digit3=-2 (val=1,sign=1,double=1), others val=0 -> result=16'h4000.
REQ-033 op_1=8'h55, all digits val=0 with sign=1 and double=1, val[4]=1 -> result=16'h0000.
REQ-034 op_1=8'h07 as in REQ-031, out_ready held low 5 cycles with in_valid=1 and new operands -> result stays 16'h0015, in_ready=0; one cycle after out_ready=1, in_ready=1.
REQ-035 rst_n pulsed low during the second RUN cycle -> out_valid=0, result=0 and in_ready=1 while reset is low; no result is produced afterwards.
REQ-036 Back-to-back: in_valid and out_ready held high, two sets as in REQ-031 and REQ-032 -> 16'h0015 then 16'h4000, 6 cycles apart.
